// File: rtl/layer3_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : layer3_argmax
//  Description : Argmax decision stage behind the layer-3 neuron nodes.
//                After a start pulse it waits LATENCY cycles for the neuron
//                outputs to settle. It then snapshots every class score and
//                scans the snapshot one class per cycle. When the scan ends it
//                presents the winning class index and score with a one-cycle
//                valid pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_CLASSES : number of layer-3 nodes (2..255)
//    LATENCY     : cycles from start to stable Nx (>= 1)
//    THRESH      : minimum winning score (used only with ARGMAX_THRESH_EN)
//  Ports
//    clk         : clock, rising edge
//    reset       : synchronous active-high reset
//    start       : new features presented to layer 3 this cycle
//    Nx          : packed unsigned scores, class i at [32i+31:32i]
//    busy        : classification in progress
//    valid       : one-cycle result strobe
//    class_idx   : winning class (NUM_CLASSES = reject when thresholding)
//    max_score   : score of the winning class
//  Configuration macro
//    ARGMAX_THRESH_EN : when defined, a best score below THRESH is reported
//                       as the reject code NUM_CLASSES
// ============================================================================
module layer3_argmax #(
  parameter int          NUM_CLASSES = 4,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] THRESH      = 32'd0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [32*NUM_CLASSES-1:0]   Nx,
  output logic                        busy,
  output logic                        valid,
  output logic [7:0]                  class_idx,
  output logic [31:0]                 max_score
);

  localparam int                  c_WCNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(LATENCY - 1);
  localparam logic [7:0]          c_IDX_LAST  = 8'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_WCNT_W-1:0]   r_wcnt;
  logic [7:0]            r_idx;
  logic [7:0]            r_best_idx;
  logic [31:0]           r_best_val;
  logic [31:0]           r_buf [NUM_CLASSES];
  logic                  r_valid;
  logic [7:0]            r_class_idx;
  logic [31:0]           r_max_score;

  logic [31:0]           w_cur;
  logic [7:0]            w_final_idx;

  // Score of the class currently under inspection in the snapshot.
  always_comb begin
    w_cur = 32'd0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (r_idx == 8'(i)) begin
        w_cur = r_buf[i];
      end
    end
  end

`ifdef ARGMAX_THRESH_EN
  assign w_final_idx = (r_best_val < THRESH) ? 8'(NUM_CLASSES) : r_best_idx;
`else
  // The threshold is not used in this build. Fold it into a sink so that
  // lint does not report an unused parameter.
  logic w_unused_thresh;
  assign w_unused_thresh = ^THRESH;
  assign w_final_idx     = r_best_idx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_idx       <= 8'd0;
      r_best_idx  <= 8'd0;
      r_best_val  <= 32'd0;
      r_valid     <= 1'b0;
      r_class_idx <= 8'd0;
      r_max_score <= 32'd0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_buf[i] <= 32'd0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_WAIT;
            r_wcnt  <= '0;
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + c_WCNT_W'(1);
          if (r_wcnt == c_WCNT_LAST) begin
            // Snapshot the settled neuron outputs. Class 0 seeds the
            // running maximum, so the scan starts at class 1.
            for (int i = 0; i < NUM_CLASSES; i++) begin
              r_buf[i] <= Nx[32*i +: 32];
            end
            r_best_val <= Nx[31:0];
            r_best_idx <= 8'd0;
            r_idx      <= 8'd1;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          // The comparison is strict, so on a tie the lower index is kept.
          if (w_cur > r_best_val) begin
            r_best_val <= w_cur;
            r_best_idx <= r_idx;
          end
          r_idx <= r_idx + 8'd1;
          if (r_idx == c_IDX_LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_class_idx <= w_final_idx;
          r_max_score <= r_best_val;
          r_valid     <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign valid     = r_valid;
  assign class_idx = r_class_idx;
  assign max_score = r_max_score;

endmodule
`default_nettype wire
